// File: rtl/bcd2deci_stream_if.sv
// Handshake bundle between a BCD digit source, the decoder and a one-hot consumer.
// The master side drives digits and the consumer's ready; the slave side is the decoder.
interface bcd2deci_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_bcd;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_dec;
    logic       out_err;

    modport master (
        output in_valid,
        output in_bcd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_dec,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_bcd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_dec,
        output out_err
    );
endinterface

// File: rtl/bcd2deci_stream.sv
// Streaming BCD-to-decimal decoder.
// Digits are decoded when accepted and stored as {dec[9:0], err} in a 2-entry
// buffer (head/tail registers); the head register drives the outputs directly.
// in_ready and out_valid are flops loaded from the next occupancy state, so
// in_ready never depends combinationally on out_ready.
module bcd2deci_stream #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd2deci_stream_if.slave     st,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // Map a BCD code to a buffer entry {one-hot decimal, invalid flag}.
    function automatic logic [10:0] decode_bcd(input logic [3:0] code);
        logic [10:0] entry;
        case (code)
            4'd0:    entry = {10'h001, 1'b0};
            4'd1:    entry = {10'h002, 1'b0};
            4'd2:    entry = {10'h004, 1'b0};
            4'd3:    entry = {10'h008, 1'b0};
            4'd4:    entry = {10'h010, 1'b0};
            4'd5:    entry = {10'h020, 1'b0};
            4'd6:    entry = {10'h040, 1'b0};
            4'd7:    entry = {10'h080, 1'b0};
            4'd8:    entry = {10'h100, 1'b0};
            4'd9:    entry = {10'h200, 1'b0};
            default: entry = {10'h000, 1'b1};
        endcase
        return entry;
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [10:0]          head_r;
    logic [10:0]          head_nxt_s;
    logic [10:0]          tail_r;
    logic [10:0]          tail_nxt_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [ERR_CNT_W-1:0] err_count_r;
    logic [10:0]          entry_s;
    logic                 accept_s;
    logic                 pop_s;
    logic                 err_inc_s;

    assign entry_s   = decode_bcd(st.in_bcd);
    assign accept_s  = st.in_valid && in_ready_r;
    assign pop_s     = out_valid_r && st.out_ready;
    assign err_inc_s = accept_s && entry_s[0] && (err_count_r != ERR_MAX);

    assign st.in_ready  = in_ready_r;
    assign st.out_valid = out_valid_r;
    assign st.out_dec   = head_r[10:1];
    assign st.out_err   = head_r[0];
    assign err_count    = err_count_r;

    // Occupancy next-state and buffer movement: the new digit lands in head when
    // the buffer is (or becomes) otherwise empty, in tail when head is still held.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ONE;
                    head_nxt_s  = entry_s;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && pop_s) begin
                    state_nxt_s = ONE;
                    head_nxt_s  = entry_s;
                end else if (accept_s) begin
                    state_nxt_s = FULL;
                    tail_nxt_s  = entry_s;
                end else if (pop_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    state_nxt_s = ONE;
                    head_nxt_s  = tail_r;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // Occupancy state, buffer entries and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            head_r      <= 11'b0;
            tail_r      <= 11'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            in_ready_r  <= (state_nxt_s != FULL);
            out_valid_r <= (state_nxt_s != EMPTY);
        end
    end

    // Saturating count of accepted invalid codes; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else if (clr_err) begin
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else if (err_inc_s) begin
            err_count_r <= err_count_r + ERR_ONE;
        end else begin
            err_count_r <= err_count_r;
        end
    end

endmodule
